aidc_lite_block_assembler: RTL
==============================

// Module: aidc_lite_block_assembler
// PURPOSE
//  Downstream of the AIDC-Lite code concatenator. Collects its (addr, 64b word) write stream into a
//  512-bit block buffer, detects block end from the done/fail levels, then emits one 512-bit block
//  over a valid/ready port: the compressed block (comp_o=1) or, on fail, the latched raw block (comp_o=0).
//  Double-buffered (collect buffer + output register) because the concatenator has no backpressure.
// PARAMETERS
//  BLK_WORDS   8    64-bit words per block; the collect index (wr_addr_i) is 3 bits.
//  WORD_W      64   width of each write word.
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    synchronous active-low reset
//  wr_valid_i   in   1    concatenator word write strobe
//  wr_addr_i    in   3    word index 0..7
//  wr_data_i    in   64   word data
//  done_i       in   1    concatenator done level (1 = idle/complete, falls at block start)
//  fail_i       in   1    concatenator fail, sampled on the done_i rising edge
//  raw_valid_i  in   1    original uncompressed block strobe (one per block)
//  raw_data_i   in   512  original block
//  valid_o      out  1    output block valid
//  ready_i      in   1    consumer accept
//  data_o       out  512  output block; word 0 in [511:448], word 7 in [63:0]
//  comp_o       out  1    1 = compressed payload, 0 = raw fallback
//  nwords_o     out  4    compressed: highest written addr+1 (1..8); raw: 8
//  busy_o       out  1    block in collection (done_i seen low, rise not yet seen)
//  ovf_o        out  1    sticky: block completed while output register still held an unaccepted block
// BEHAVIOUR
//  Reset: valid_o=0, data_o=0, comp_o=0, nwords_o=0, busy_o=0, ovf_o=0, collect buffer=0,
//   done_q=1, max_addr=0, raw_ok=0. Reset mid-block drops the partial block and any held output.
//  Edge detection: done_q registers done_i. Falling (done_q=1, done_i=0) = block start: clear the
//   collect buffer and max_addr; busy_o<=1. A write in the same cycle lands in the cleared buffer (write wins).
//  Writes: wr_valid_i=1 stores wr_data_i into word wr_addr_i; max_addr<=max(max_addr, wr_addr_i);
//   track any_wr. Writes while busy_o=0 and no falling edge are ignored.
//  Completion: rising (done_q=0, done_i=1). A write in the same cycle is included in the block.
//   The completed block, including that write, moves to the output register with a 1-cycle latency:
//   fail_i=0 -> data_o=collect buffer, comp_o=1, nwords_o=max_addr+1.
//   fail_i=1 -> data_o=raw buffer, comp_o=0, nwords_o=8.
//   valid_o<=1; busy_o<=0; raw_ok<=0.
//  Raw latch: raw_valid_i=1 loads raw_data_i and sets raw_ok. If it fires in the completion cycle,
//   the new data belongs to the next block and is not used. fail at completion with raw_ok=0 sets ovf_o.
//  Output handshake: the block transfers when valid_o&ready_i. data_o/comp_o/nwords_o stay stable while
//   valid_o=1 and ready_i=0. On completion while valid_o=1 and ready_i=0, the new block overwrites
//   the register and ovf_o<=1 (sticky until reset). Completion coinciding with a transfer is
//   legal: valid_o stays 1 and the new block is loaded.
//  Write-address wrap: wr_addr_i is 3 bits; a 9th word overwrites a lower index. This cannot occur,
//   since the concatenator suppresses writes with addr>=8.
//  No combinational path from inputs to outputs; all outputs are registered.
// TESTING
//  1 Block of 8 writes addr0..7 data=addr*0x1111, done rise with write 7, fail=0, ready=1 ->
//    valid_o 1 cycle later, comp_o=1, nwords_o=8, data_o[511:448]=0, data_o[63:0]=0x7777.
//  2 Short block: writes addr0..2, done rises with the 2nd cycle after addr2 -> nwords_o=3,
//    data_o words 3..7 = 0, even when the previous block had nonzero words there.
//  3 fail=1 at done rise, raw_data_i=0xA5..A5 latched earlier -> comp_o=0, nwords_o=8,
//    data_o=0xA5..A5; repeat with no raw_valid_i -> ovf_o=1.
//  4 ready_i=0 for 20 cycles -> outputs stable; second completion during stall -> ovf_o=1 and new data
//    shown; completion coinciding with a transfer -> ovf_o stays 0.
//  5 Done falls and the addr0 write arrive in the same cycle -> word0 kept, others zero.
//    Back-to-back blocks (done high for 1 cycle) -> two valid_o blocks in order.
//  6 rst_n=0 mid-block after 4 writes -> all outputs reset; next full block is assembled correctly.

Source files
------------

// File: rtl/aidc_lite_block_assembler.sv
// Collects the concatenator's word-write stream into a block buffer and emits one
// registered block per done_i rising edge: compressed words, or the latched raw block on fail.
module aidc_lite_block_assembler #(
  parameter  int unsigned BLK_WORDS = 8,
  parameter  int unsigned WORD_W    = 64,
  localparam int unsigned AW        = $clog2(BLK_WORDS),
  localparam int unsigned NW        = AW + 1,
  localparam int unsigned BLK_W     = BLK_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              done_i,
  input  logic              fail_i,
  input  logic              raw_valid_i,
  input  logic [BLK_W-1:0]  raw_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [BLK_W-1:0]  data_o,
  output logic              comp_o,
  output logic [NW-1:0]     nwords_o,
  output logic              busy_o,
  output logic              ovf_o
);

  // Word a lives at packed index BLK_WORDS-1-a so word 0 lands in the top bits of data_o.
  logic [BLK_WORDS-1:0][WORD_W-1:0] buf_q, buf_d;
  logic [AW-1:0]                    max_addr_q, max_addr_d;
  logic [BLK_W-1:0]                 raw_q, raw_d;
  logic                             raw_ok_q, raw_ok_d;
  logic                             done_q;
  logic                             busy_q, busy_d;
  logic                             valid_q, valid_d;
  logic [BLK_W-1:0]                 data_q, data_d;
  logic                             comp_q, comp_d;
  logic [NW-1:0]                    nwords_q, nwords_d;
  logic                             ovf_q, ovf_d;
  logic                             fall, rise;

  always_comb begin
    buf_d      = buf_q;
    max_addr_d = max_addr_q;
    raw_d      = raw_q;
    raw_ok_d   = raw_ok_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    data_d     = data_q;
    comp_d     = comp_q;
    nwords_d   = nwords_q;
    ovf_d      = ovf_q;
    fall       = done_q & ~done_i;
    rise       = ~done_q & done_i;

    if (fall) begin
      buf_d      = '0;
      max_addr_d = '0;
      busy_d     = 1'b1;
    end

    // A write in the falling-edge cycle lands after the clear; one in the rising cycle is kept.
    if (wr_valid_i && (busy_q || fall)) begin
      buf_d[AW'(BLK_WORDS - 1) - wr_addr_i] = wr_data_i;
      if (wr_addr_i > max_addr_d) begin
        max_addr_d = wr_addr_i;
      end
    end

    if (raw_valid_i) begin
      raw_d    = raw_data_i;
      raw_ok_d = 1'b1;
    end

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    // Completion uses the raw block latched before this cycle; a same-cycle raw strobe is for the next block.
    if (rise) begin
      busy_d   = 1'b0;
      valid_d  = 1'b1;
      raw_ok_d = raw_valid_i;
      if (fail_i) begin
        data_d   = raw_q;
        comp_d   = 1'b0;
        nwords_d = NW'(BLK_WORDS);
        if (!raw_ok_q) begin
          ovf_d = 1'b1;
        end
      end else begin
        data_d   = buf_d;
        comp_d   = 1'b1;
        nwords_d = NW'(max_addr_d) + NW'(1);
      end
      if (valid_q && !ready_i) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q      <= '0;
      max_addr_q <= '0;
      raw_q      <= '0;
      raw_ok_q   <= 1'b0;
      done_q     <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      comp_q     <= 1'b0;
      nwords_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      max_addr_q <= max_addr_d;
      raw_q      <= raw_d;
      raw_ok_q   <= raw_ok_d;
      done_q     <= done_i;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      comp_q     <= comp_d;
      nwords_q   <= nwords_d;
      ovf_q      <= ovf_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign comp_o   = comp_q;
  assign nwords_o = nwords_q;
  assign busy_o   = busy_q;
  assign ovf_o    = ovf_q;

endmodule
